mix_columns_engine: RTL
=======================

MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 The block SHALL have parameter COLS_PER_CYCLE, default 1, columns (32-bit words) transformed per compute cycle; legal values 1, 2, 4.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, input state available.
REQ-005 The block SHALL have port in_ready, output, 1, engine can accept a state.
REQ-006 The block SHALL have port in_data, input, 128, AES state: column c = in_data[127-32c -: 32], byte r of a column = bits [31-8r -: 8].
REQ-007 The block SHALL have port in_inv, input, 1, 1 = InvMixColumns, 0 = MixColumns.
REQ-008 The block SHALL have port out_valid, output, 1, result available.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 The block SHALL have port out_data, output, 128, transformed state, same packing as in_data.
REQ-011 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-013 In IDLE, when in_valid & in_ready: latch in_data, in_inv, clear column counter, go BUSY; otherwise stay in IDLE.
REQ-014 Each BUSY cycle SHALL transform COLS_PER_CYCLE consecutive columns starting at the counter value, write them into the result register and advance the counter by COLS_PER_CYCLE.
REQ-015 Forward column math SHALL be s0'=2s0^3s1^s2^s3, s1'=s0^2s1^3s2^s3, s2'=s0^s1^2s2^3s3, s3'=3s0^s1^s2^2s3.
REQ-016 Inverse column math SHALL use coefficient rows {0e,0b,0d,09} rotated right one byte per output row.
REQ-017 GF(2^8) multiplies SHALL use xtime with reduction polynomial 0x11B; all sums are XOR; no carries.
REQ-018 On the edge processing the last column group: go DONE, assert out_valid; latency accept-edge to out_valid-edge = 4/COLS_PER_CYCLE cycles (4, 2, 1).
REQ-019 In DONE, out_data and out_valid SHALL hold stable while out_ready = 0.
REQ-020 In DONE with out_ready = 1: deassert out_valid, go IDLE on that edge; the next accept is possible the following cycle.
REQ-021 in_valid, in_data, in_inv changes while BUSY or DONE SHALL have no effect.
REQ-022 out_data SHALL retain the last result after return to IDLE until overwritten.
REQ-023 An illegal COLS_PER_CYCLE SHALL cause an elaboration-time error.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, counter 0, out_valid 0, out_data 0, busy 0, in_ready 1 after release; this applies mid-BUSY or mid-DONE with the in-flight state discarded.
REQ-025 The first accept SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-026 Macro MIXCOL_INV_EN defined: REQ-016 datapath present; in_inv selects the mode per accepted state.
REQ-027 Macro MIXCOL_INV_EN undefined: no inverse datapath; in_inv port remains but is ignored; all transforms are forward.

Verification
REQ-028 COLS_PER_CYCLE=1, forward, in_data=db135345_f20a225c_01010101_2d26314c -> out_data=8e4da1bc_9fdc589d_01010101_4d7ebdf8, out_valid 4 cycles after accept.
REQ-029 MIXCOL_INV_EN defined, in_inv=1, in_data=8e4da1bc_9fdc589d_01010101_4d7ebdf8 -> out_data=db135345_f20a225c_01010101_2d26314c; repeat with COLS_PER_CYCLE=2 (latency 2) and 4 (latency 1).
REQ-030 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data/out_valid stable, in_ready 0 throughout, in_data toggling ignored; out_ready=1 -> IDLE next edge.
REQ-031 Reset mid-BUSY (after 2 of 4 columns): rst_n low -> out_valid 0, out_data 0, busy 0 immediately; new state c6c6c6c6_d4d4d4d5_c6c6c6c6_d4d4d4d5 -> c6c6c6c6_d5d5d7d6_c6c6c6c6_d5d5d7d6.
REQ-032 MIXCOL_INV_EN undefined, in_inv=1, in_data=db135345_... (REQ-028 vector) -> forward result of REQ-028.
REQ-033 Back-to-back: in_valid held high with two states -> second accepted exactly one cycle after the first result handshake; both results correct.

Source files
------------

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: COLS_PER_CYCLE columns per cycle, valid/ready in and out.
// Define MIXCOL_INV_EN to build the inverse datapath; otherwise in_inv is ignored and all transforms are forward.
module mix_columns_engine #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned NCOLS = 4;
    localparam int unsigned CW    = 2;
    localparam logic [CW-1:0] STEP = CW'(COLS_PER_CYCLE);
    localparam logic [CW-1:0] LAST = CW'(NCOLS - COLS_PER_CYCLE);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [127:0]    src, src_nxt;
    logic [127:0]    res_nxt;
    logic            out_valid_nxt;
    logic            in_ready_nxt;
    logic            busy_nxt;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // 2a ^ 3b ^ c ^ d; output rows are byte rotations of the input column
    function automatic logic [7:0] fwd_row(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
        return xtime(a) ^ xtime(b) ^ b ^ c ^ d;
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = col;
        return {fwd_row(s0, s1, s2, s3), fwd_row(s1, s2, s3, s0),
                fwd_row(s2, s3, s0, s1), fwd_row(s3, s0, s1, s2)};
    endfunction

`ifdef MIXCOL_INV_EN
    logic inv_q, inv_nxt;

    // 0e*a ^ 0b*b ^ 0d*c ^ 09*d built from xtime chains
    function automatic logic [7:0] inv_row(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
        logic [7:0] a2, a4, a8, b2, b8, c4, c8, d8;
        a2 = xtime(a); a4 = xtime(a2); a8 = xtime(a4);
        b2 = xtime(b); b8 = xtime(xtime(b2));
        c4 = xtime(xtime(c)); c8 = xtime(c4);
        d8 = xtime(xtime(xtime(d)));
        return (a8 ^ a4 ^ a2) ^ (b8 ^ b2 ^ b) ^ (c8 ^ c4 ^ c) ^ (d8 ^ d);
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = col;
        return {inv_row(s0, s1, s2, s3), inv_row(s1, s2, s3, s0),
                inv_row(s2, s3, s0, s1), inv_row(s3, s0, s1, s2)};
    endfunction

    function automatic logic [31:0] xform(input logic [31:0] col, input logic inv);
        return inv ? mix_inv(col) : mix_fwd(col);
    endfunction
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;

    function automatic logic [31:0] xform(input logic [31:0] col);
        return mix_fwd(col);
    endfunction
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        src_nxt       = src;
        res_nxt       = out_data;
        out_valid_nxt = out_valid;
`ifdef MIXCOL_INV_EN
        inv_nxt       = inv_q;
`endif
        case (state)
            IDLE: begin
                out_valid_nxt = 1'b0;
                if (in_valid && in_ready) begin
                    src_nxt   = in_data;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
`ifdef MIXCOL_INV_EN
                    inv_nxt   = in_inv;
`endif
                end
            end
            BUSY: begin
                for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
`ifdef MIXCOL_INV_EN
                    res_nxt[127 - 32*(32'(cnt) + k) -: 32] =
                        xform(src[127 - 32*(32'(cnt) + k) -: 32], inv_q);
`else
                    res_nxt[127 - 32*(32'(cnt) + k) -: 32] =
                        xform(src[127 - 32*(32'(cnt) + k) -: 32]);
`endif
                end
                cnt_nxt = cnt + STEP;
                if (cnt == LAST) begin
                    state_nxt     = DONE;
                    out_valid_nxt = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt     = IDLE;
                out_valid_nxt = 1'b0;
            end
        endcase
        in_ready_nxt = (state_nxt == IDLE);
        busy_nxt     = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            src       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef MIXCOL_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            src       <= src_nxt;
            out_data  <= res_nxt;
            out_valid <= out_valid_nxt;
            in_ready  <= in_ready_nxt;
            busy      <= busy_nxt;
`ifdef MIXCOL_INV_EN
            inv_q     <= inv_nxt;
`endif
        end
    end

endmodule
